// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard control unit and its helpers.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      EX_BUSY    = 2'd2
   } hz_state_e;

   localparam int unsigned ZERO_REG = 0;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_control_unit_match.sv
// Combinational load-use compare of the EX destination against the ID sources.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int REG_AW           = 5,
   parameter int ZERO_REG_EXCLUDE = 1
) (
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   output logic              hz
);

   logic rd_ok;
   logic src_match;

   // x0 always reads as zero, so a load targeting it can never create a hazard
   assign rd_ok     = (ZERO_REG_EXCLUDE == 0) || (ex_rd != REG_AW'(ZERO_REG));
   assign src_match = (id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd));
   assign hz        = ex_mem_read && rd_ok && src_match;

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: load-use stalls, multi-cycle EX holds, branch flushes,
// and a saturating stall-cycle counter.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW           = 5,
   parameter int LOAD_LATENCY     = 1,
   parameter int MULDIV_CYCLES    = 4,
   parameter int ZERO_REG_EXCLUDE = 1,
   parameter int CNT_W            = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ID_EX_RegisterRd,
   input  logic              ID_EX_MEMRead,
   input  logic              ID_EX_MultiCycle,
   input  logic [REG_AW-1:0] IF_ID_RegisterRs1,
   input  logic [REG_AW-1:0] IF_ID_RegisterRs2,
   input  logic              IF_ID_Rs1Used,
   input  logic              IF_ID_Rs2Used,
   input  logic              BranchTaken,
   output logic              PCWrite,
   output logic              IF_ID_Write,
   output logic              IF_ID_Flush,
   output logic              ID_EX_Write,
   output logic              ID_EX_MuxSelect,
   output logic              EX_MEM_MuxSelect,
   output logic [CNT_W-1:0]  StallCount
);

   localparam int unsigned CNT_MAX = max_u(LOAD_LATENCY - 1, MULDIV_CYCLES - 1);
   localparam int unsigned CW      = max_u(3, $clog2(CNT_MAX + 1));
   localparam int unsigned LL_LOAD = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0;
   localparam int unsigned MD_LOAD = MULDIV_CYCLES - 2;

   hz_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             hz;
   logic             pc_w, ifid_w, ifid_flush, idex_w, idex_mux, exmem_mux;

   hazard_match #(
      .REG_AW           (REG_AW),
      .ZERO_REG_EXCLUDE (ZERO_REG_EXCLUDE)
   ) u_match (
      .ex_rd       (ID_EX_RegisterRd),
      .ex_mem_read (ID_EX_MEMRead),
      .id_rs1      (IF_ID_RegisterRs1),
      .id_rs2      (IF_ID_RegisterRs2),
      .id_rs1_used (IF_ID_Rs1Used),
      .id_rs2_used (IF_ID_Rs2Used),
      .hz          (hz)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_w       = 1'b1;
      ifid_w     = 1'b1;
      ifid_flush = 1'b0;
      idex_w     = 1'b1;
      idex_mux   = 1'b0;
      exmem_mux  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (BranchTaken) begin
               ifid_flush = 1'b1;
               idex_mux   = 1'b1;
            end else if (ID_EX_MultiCycle) begin
               pc_w      = 1'b0;
               ifid_w    = 1'b0;
               idex_w    = 1'b0;
               exmem_mux = 1'b1;
               cnt_d     = CW'(MD_LOAD);
               state_d   = EX_BUSY;
            end else if (hz) begin
               pc_w     = 1'b0;
               ifid_w   = 1'b0;
               idex_mux = 1'b1;
               if (LOAD_LATENCY > 1) begin
                  cnt_d   = CW'(LL_LOAD);
                  state_d = LOAD_STALL;
               end
            end
         end
         LOAD_STALL: begin
            if (BranchTaken) begin
               ifid_flush = 1'b1;
               idex_mux   = 1'b1;
               state_d    = IDLE;
            end else begin
               pc_w     = 1'b0;
               ifid_w   = 1'b0;
               idex_mux = 1'b1;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         EX_BUSY: begin
            // branch resolution is frozen along with the op occupying EX
            pc_w      = 1'b0;
            ifid_w    = 1'b0;
            idex_w    = 1'b0;
            exmem_mux = 1'b1;
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         state_d    = IDLE;
         cnt_d      = '0;
         pc_w       = 1'b1;
         ifid_w     = 1'b1;
         ifid_flush = 1'b0;
         idex_w     = 1'b1;
         idex_mux   = 1'b0;
         exmem_mux  = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (reset)                                 stall_cnt_d = '0;
      else if (!pc_w && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign PCWrite          = pc_w;
   assign IF_ID_Write      = ifid_w;
   assign IF_ID_Flush      = ifid_flush;
   assign ID_EX_Write      = idex_w;
   assign ID_EX_MuxSelect  = idex_mux;
   assign EX_MEM_MuxSelect = exmem_mux;
   assign StallCount       = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: unit A (LOAD_LATENCY=1, 32-bit counter) via a vector table,
// unit B (LOAD_LATENCY=3, 2-bit counter) via hand sequences.
module tb_hazard_control_unit;

   localparam logic [5:0] DEF   = 6'b110100;
   localparam logic [5:0] LSTL  = 6'b000110;
   localparam logic [5:0] MULT  = 6'b000001;
   localparam logic [5:0] BRFL  = 6'b111110;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic       mr, mc, u1, u2, br;
   logic [4:0] rd, rs1, rs2;

   logic       a_pcw, a_ifw, a_iff, a_idw, a_idm, a_exm;
   logic       b_pcw, b_ifw, b_iff, b_idw, b_idm, b_exm;
   logic [31:0] a_cnt;
   logic [1:0]  b_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_control_unit #(.REG_AW(5), .LOAD_LATENCY(1), .MULDIV_CYCLES(4),
                         .ZERO_REG_EXCLUDE(1), .CNT_W(32)) dut_a (
      .clk(clk), .reset(rst_a),
      .ID_EX_RegisterRd(rd), .ID_EX_MEMRead(mr), .ID_EX_MultiCycle(mc),
      .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
      .IF_ID_Rs1Used(u1), .IF_ID_Rs2Used(u2), .BranchTaken(br),
      .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_iff),
      .ID_EX_Write(a_idw), .ID_EX_MuxSelect(a_idm), .EX_MEM_MuxSelect(a_exm),
      .StallCount(a_cnt));

   hazard_control_unit #(.REG_AW(5), .LOAD_LATENCY(3), .MULDIV_CYCLES(4),
                         .ZERO_REG_EXCLUDE(1), .CNT_W(2)) dut_b (
      .clk(clk), .reset(rst_b),
      .ID_EX_RegisterRd(rd), .ID_EX_MEMRead(mr), .ID_EX_MultiCycle(mc),
      .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
      .IF_ID_Rs1Used(u1), .IF_ID_Rs2Used(u2), .BranchTaken(br),
      .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff),
      .ID_EX_Write(b_idw), .ID_EX_MuxSelect(b_idm), .EX_MEM_MuxSelect(b_exm),
      .StallCount(b_cnt));

   typedef struct {
      logic       rst, mr, mc;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, br;
      logic [5:0] ctl;
      int         cnt;
   } vec_t;

   vec_t vec[26];

   function automatic vec_t mk(input logic r, input logic m, input logic c,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic x1, input logic x2, input logic b,
                               input logic [5:0] e, input int k);
      vec_t v;
      v.rst = r; v.mr = m; v.mc = c; v.rd = d; v.rs1 = s1; v.rs2 = s2;
      v.u1 = x1; v.u2 = x2; v.br = b; v.ctl = e; v.cnt = k;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge; outputs settle before the next rise.
   task automatic drive(input logic r, input logic m, input logic c,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic x1, input logic x2, input logic b);
      @(negedge clk);
      mr = m; mc = c; rd = d; rs1 = s1; rs2 = s2; u1 = x1; u2 = x2; br = b;
      rst_b = r;
      #4;
   endtask

   task automatic chk_b(input string name, input logic [5:0] e, input int k);
      check({name, "_ctl"}, {26'd0, b_pcw, b_ifw, b_iff, b_idw, b_idm, b_exm}, {26'd0, e});
      check({name, "_cnt"}, {30'd0, b_cnt}, k);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      mr = 0; mc = 0; u1 = 0; u2 = 0; br = 0; rd = 0; rs1 = 0; rs2 = 0;

      //            rst mr mc rd  rs1 rs2 u1 u2 br  ctl   cnt
      vec[0]  = mk(1, 1, 0, 5,  5,  0,  1, 0, 0, DEF,  0);
      vec[1]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, DEF,  0);
      vec[2]  = mk(0, 1, 0, 5,  5,  0,  1, 0, 0, LSTL, 0);
      vec[3]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, DEF,  1);
      vec[4]  = mk(0, 1, 0, 0,  0,  0,  1, 0, 0, DEF,  1);
      vec[5]  = mk(0, 1, 0, 7,  3,  7,  1, 0, 0, DEF,  1);
      vec[6]  = mk(0, 1, 0, 7,  3,  7,  1, 1, 0, LSTL, 1);
      vec[7]  = mk(0, 0, 0, 5,  5,  0,  1, 0, 0, DEF,  2);
      vec[8]  = mk(0, 1, 0, 5,  5,  0,  1, 0, 1, BRFL, 2);
      vec[9]  = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, DEF,  2);
      vec[10] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 2);
      vec[11] = mk(0, 0, 1, 0,  0,  0,  0, 0, 1, MULT, 3);
      vec[12] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 4);
      vec[13] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 5);
      vec[14] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, DEF,  6);
      vec[15] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 6);
      vec[16] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 7);
      vec[17] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 8);
      vec[18] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 9);
      vec[19] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 10);
      vec[20] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 11);
      vec[21] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 12);
      vec[22] = mk(0, 0, 1, 0,  0,  0,  0, 0, 0, MULT, 13);
      vec[23] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, DEF,  14);
      vec[24] = mk(0, 0, 1, 0,  0,  0,  0, 0, 1, BRFL, 14);
      vec[25] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0, DEF,  14);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         rst_a = vec[i].rst; mr = vec[i].mr; mc = vec[i].mc; rd = vec[i].rd;
         rs1 = vec[i].rs1; rs2 = vec[i].rs2; u1 = vec[i].u1; u2 = vec[i].u2; br = vec[i].br;
         #4;
         check($sformatf("vecA%0d_ctl", i),
               {26'd0, a_pcw, a_ifw, a_iff, a_idw, a_idm, a_exm}, {26'd0, vec[i].ctl});
         check($sformatf("vecA%0d_cnt", i), a_cnt, vec[i].cnt);
      end

      rst_a = 1'b1;
      // three-cycle load stall; hazard only present on the detect cycle
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_rst", DEF, 0);
      drive(0, 1, 0, 5, 5, 0, 1, 0, 0); chk_b("b_ls1", LSTL, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_ls2", LSTL, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_ls3", LSTL, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_ls_done", DEF, 3);
      // counter is all-ones now; another stall must not wrap it
      drive(0, 1, 0, 9, 0, 9, 0, 1, 0); chk_b("b_sat1", LSTL, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_sat2", LSTL, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_sat3", LSTL, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_sat_done", DEF, 3);
      // reset in the second stall cycle abandons the stall
      drive(0, 1, 0, 5, 5, 0, 1, 0, 0); chk_b("b_rm1", LSTL, 3);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_rm_rst", DEF, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_rm_after", DEF, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_rm_idle", DEF, 0);
      // taken branch during a load stall flushes and returns to idle
      drive(0, 1, 0, 6, 0, 6, 0, 1, 0); chk_b("b_br1", LSTL, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); chk_b("b_br_fl", BRFL, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk_b("b_br_idle", DEF, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised successor to the pipeline's load-use hazard detector.
- Detects load-use hazards against a configurable load latency, with per-operand use qualifiers and x0 exclusion.
- Holds the pipeline for multi-cycle EX operations (mul/div) and generates branch flushes.
- Sits in ID; drives PC/IF_ID/ID_EX/EX_MEM write-enable and bubble-mux controls; exposes a stall performance counter.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LATENCY, 1, total stall cycles per load-use hazard (1..8).
- MULDIV_CYCLES, 4, total EX-hold cycles per multi-cycle op (2..32).
- ZERO_REG_EXCLUDE, 1, when 1 a match on register 0 never stalls.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ID_EX_RegisterRd  in  REG_AW  destination of the instruction in EX.
- ID_EX_MEMRead  in  1  the instruction in EX is a load.
- ID_EX_MultiCycle  in  1  the instruction in EX is a multi-cycle op.
- IF_ID_RegisterRs1  in  REG_AW  source 1 of the instruction in ID.
- IF_ID_RegisterRs2  in  REG_AW  source 2 of the instruction in ID.
- IF_ID_Rs1Used  in  1  rs1 is read by the instruction in ID.
- IF_ID_Rs2Used  in  1  rs2 is read by the instruction in ID.
- BranchTaken  in  1  EX resolved a taken branch or jump this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- ID_EX_Write  out  1  ID/EX register enable.
- ID_EX_MuxSelect  out  1  insert bubble into ID/EX.
- EX_MEM_MuxSelect  out  1  insert bubble into EX/MEM.
- StallCount  out  CNT_W  saturating count of cycles with PCWrite=0.

Behaviour:
Reset (synchronous, active-high):
- State=IDLE, counter=0, StallCount=0.
- While reset is high, outputs are forced to the no-stall defaults: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all flush/bubble outputs 0.
- Reset mid-stall abandons the stall immediately.

Hazard term:
- hz = ID_EX_MEMRead and ((Rs1Used and rs1==rd) or (Rs2Used and rs2==rd)).
- If ZERO_REG_EXCLUDE=1, hz is additionally gated by rd!=0.

States: IDLE, LOAD_STALL, EX_BUSY. 3-bit-capable down-counter sized to the larger of LOAD_LATENCY-1 and MULDIV_CYCLES-1.

IDLE, priority order:
- (1) BranchTaken: IF_ID_Flush=1, ID_EX_MuxSelect=1, PCWrite=1. Overrides hz; stay in IDLE.
- (2) ID_EX_MultiCycle: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_MuxSelect=1. Counter loads MULDIV_CYCLES-2; go to EX_BUSY.
- (3) hz: PCWrite=0, IF_ID_Write=0, ID_EX_MuxSelect=1 (first stall cycle, same cycle as detection).
  - If LOAD_LATENCY>1: counter loads LOAD_LATENCY-2; go to LOAD_STALL.
  - Otherwise stay in IDLE.
- (4) Otherwise: all defaults.

LOAD_STALL:
- Outputs as in (3).
- At counter==0, return to IDLE; else decrement.
- BranchTaken here (EX holds a bubble, so not expected) still wins: apply the flush outputs and return to IDLE.

EX_BUSY:
- Outputs as in (2).
- At counter==0, return to IDLE; else decrement.
- BranchTaken is ignored.
- ID_EX_MultiCycle remains high because ID/EX is frozen; it is not re-triggered until IDLE is re-entered.
- Back-to-back multi-cycle ops each hold for the full MULDIV_CYCLES.

Total hold:
- Load-use: exactly LOAD_LATENCY cycles.
- Multi-cycle op: exactly MULDIV_CYCLES cycles.

StallCount:
- Increments on every cycle with PCWrite=0 (reset excluded).
- Saturates at all-ones; no wrap.

Decomposition:
- Shared package hazard_pkg: state encoding (IDLE=0, LOAD_STALL=1, EX_BUSY=2) and the x0 register index constant.
- One sub-module, hazard_match: the combinational hz compare, reused later for forwarding.
- The FSM, counter and StallCount stay in the top.

Test Plan:
- LOAD_LATENCY=1, load rd=5, ID rs1=5 used -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_MuxSelect=1; StallCount=1.
- LOAD_LATENCY=3, same hazard -> exactly 3 consecutive stall cycles, then defaults; StallCount=3.
- Load rd=0 with rs1=0 (ZERO_REG_EXCLUDE=1), and separately rd=7 with rs2=7 but Rs2Used=0 -> no stall.
- MULDIV_CYCLES=4, ID_EX_MultiCycle=1 -> 4 cycles with ID_EX_Write=0 and EX_MEM_MuxSelect=1; BranchTaken pulsed in cycle 2 is ignored.
- BranchTaken=1 together with hz=1 in IDLE -> IF_ID_Flush=1, ID_EX_MuxSelect=1, PCWrite=1; no stall.
- reset asserted in the 2nd of 3 LOAD_STALL cycles -> next cycle IDLE with default outputs and StallCount=0. Separately, force StallCount to all-ones and stall once more -> value holds at all-ones.
